vec_opnd_fetch: RTL and testbench
=================================

Name: vec_opnd_fetch

Overview:
Operand-fetch front end that drives the read ports of the vector register file for one issued vector uop at a time. It maps up to three source specifiers (vs1, vs2, vs3/old-vd) onto NRD read ports and sequences the reads over as many cycles as needed. It collects the returned data under the VRF's fixed 1-cycle read latency and presents a complete operand bundle downstream with a valid/ready handshake. Hazard bypass is not handled here; the VRF already forwards write port 0.

Parameters:
XLEN, 512, vector register width in bits
NRD, 2, VRF read ports owned by this block; legal values 1..3
TAGW, 8, uop tag width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
flush  input  1  kill in-flight uop
iss_valid  input  1  uop offered
iss_ready  output  1  block can accept a uop
iss_tag  input  TAGW  uop tag
iss_src_en  input  3  source enables: [0]=vs1, [1]=vs2, [2]=vs3
iss_vs1, iss_vs2, iss_vs3  input  5 each  source register indices
rd_en  output  NRD  VRF read enables
rd_addr  output  NRD*5  VRF read indices
rd_data  input  NRD*XLEN  VRF read data, valid the cycle after rd_en
opnd_valid  output  1  operand bundle valid
opnd_ready  input  1  downstream accepts bundle
opnd_tag  output  TAGW  tag of bundle
opnd_v1, opnd_v2, opnd_v3  output  XLEN each  operands; zero for disabled sources

Behaviour:
- Reset is asynchronous, active low. State=IDLE; iss_ready=1; opnd_valid=0; rd_en=0; rd_addr=0; opnd_tag, opnd_v1, opnd_v2 and opnd_v3 all zero.
- FSM states: IDLE, REQ, DRAIN, OUT.
- IDLE:
  - iss_ready=1.
  - On iss_valid, latch the tag, enables and indices.
  - Clear opnd_v* to 0.
  - Next state is REQ if any enable is set, otherwise OUT.
- REQ:
  - Pending sources are served in fixed order vs1, vs2, vs3.
  - Each cycle, the next min(NRD, pending) enabled sources are assigned to ports 0,1,... in that order: rd_en[k]=1, rd_addr[k]=index.
  - Data for reads issued in the previous cycle is captured from rd_data into the matching opnd_v* register in the same cycle.
  - If no sources remain pending after this cycle's issue, next state is DRAIN; otherwise stay in REQ.
- DRAIN: rd_en=0; capture data for the reads issued in the final REQ cycle; next state OUT.
- OUT:
  - opnd_valid=1; operands and tag are held stable.
  - On opnd_ready, return to IDLE.
  - A new uop is not accepted in the same cycle the bundle is taken.
- rd_en and rd_addr are driven combinationally from state and the pending mask. rd_addr[k]=0 whenever rd_en[k]=0. Ports not used in a cycle stay disabled.
- Latency from acceptance at cycle T to opnd_valid:
  - 0 sources: T+1.
  - n>0 sources: T + ceil(n/NRD) + 2.
- flush:
  - Flush in any state forces IDLE next cycle and drops opnd_valid.
  - Read data returning the cycle after flush is discarded.
  - iss_ready is 0 during the flush cycle.
- Simultaneous flush and iss_valid in IDLE: flush wins; the uop is not accepted.
- Reset mid-operation returns every register to its reset value immediately; in-flight reads are discarded.
- rd_data is sampled only in the cycle after the corresponding rd_en. Any other rd_data value is ignored.

Test Plan:
- Reset/idle: hold rst_n=0 → iss_ready=1, opnd_valid=0, rd_en=0, all operands 0. Release reset and check the block stays in IDLE.
- Three sources, NRD=2: accept vs1=3, vs2=7, vs3=9 at T.
  - T+1: rd_en=2'b11, addr 3 and 7.
  - T+2: rd_en=2'b01, addr 9.
  - T+4: opnd_valid=1 with the VRF contents of v3, v7 and v9 in opnd_v1, opnd_v2 and opnd_v3.
- Sparse enables: src_en=3'b100, vs3=31 → only port 0 reads 31 at T+1; opnd_valid at T+3; opnd_v1=opnd_v2=0, opnd_v3=VRF[31].
- Zero sources: src_en=0, tag=0x5A → no rd_en pulses; opnd_valid at T+1 with tag 0x5A and all operands 0.
- Backpressure: opnd_ready=0 for 5 cycles in OUT → bundle and tag stable, iss_ready=0. A new iss_valid is accepted only after the ready handshake.
- Flush: assert flush in the REQ cycle that issues vs3 → next cycle in IDLE, opnd_valid never asserts, the late rd_data is ignored. The next uop completes with correct data.

Source files
------------

// File: rtl/vec_opnd_fetch.sv
// vec_opnd_fetch: sequences up to three vector source reads over NRD VRF read ports
// and presents the collected operand bundle with a valid/ready handshake.
module vec_opnd_fetch #(
    parameter int XLEN = 512,
    parameter int NRD  = 2,
    parameter int TAGW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [TAGW-1:0]      iss_tag,
    input  logic [2:0]           iss_src_en,
    input  logic [4:0]           iss_vs1,
    input  logic [4:0]           iss_vs2,
    input  logic [4:0]           iss_vs3,
    output logic [NRD-1:0]       rd_en,
    output logic [NRD*5-1:0]     rd_addr,
    input  logic [NRD*XLEN-1:0]  rd_data,
    output logic                 opnd_valid,
    input  logic                 opnd_ready,
    output logic [TAGW-1:0]      opnd_tag,
    output logic [XLEN-1:0]      opnd_v1,
    output logic [XLEN-1:0]      opnd_v2,
    output logic [XLEN-1:0]      opnd_v3
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;
    localparam logic [2:0] NRD3  = 3'(NRD);

    logic [1:0]            state_q, state_d;
    logic [TAGW-1:0]       tag_q, tag_d;
    logic [2:0][4:0]       vs_q, vs_d;
    logic [2:0]            pend_q, pend_d;
    logic [2:0]            prev_en_q, prev_en_d;
    logic [2:0][1:0]       prev_port_q, prev_port_d;
    logic [2:0][XLEN-1:0]  v_q, v_d;
    logic [2:0]            iss_m;
    logic [2:0][1:0]       port_of;
    logic [1:0]            cnt;
    logic [2:0]            en3;
    logic [2:0][4:0]       addr3;
    logic [2:0][XLEN-1:0]  rdd3;

    // Pad the read-data bus to three lanes so the capture mux is NRD-agnostic.
    for (genvar k = 0; k < 3; k++) begin : g_rd
        if (k < NRD) begin : g_on
            assign rdd3[k] = rd_data[k*XLEN +: XLEN];
        end else begin : g_off
            assign rdd3[k] = '0;
        end
    end

    always_comb begin
        cnt     = '0;
        iss_m   = '0;
        port_of = '0;
        en3     = '0;
        addr3   = '0;
        for (int s = 0; s < 3; s++) begin
            if (state_q == REQ && pend_q[s] && {1'b0, cnt} < NRD3) begin
                iss_m[s]   = 1'b1;
                port_of[s] = cnt;
                en3[cnt]   = 1'b1;
                addr3[cnt] = vs_q[s];
                cnt        = cnt + 2'd1;
            end
        end
    end

    assign rd_en      = en3[NRD-1:0];
    assign rd_addr    = addr3[NRD-1:0];
    assign iss_ready  = state_q == IDLE && !flush;
    assign opnd_valid = state_q == OUT;
    assign opnd_tag   = tag_q;
    assign opnd_v1    = v_q[0];
    assign opnd_v2    = v_q[1];
    assign opnd_v3    = v_q[2];

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        vs_d        = vs_q;
        pend_d      = pend_q;
        prev_en_d   = '0;
        prev_port_d = port_of;
        v_d         = v_q;
        // Reads issued last cycle land now; prev_en_q is only set out of REQ.
        for (int s = 0; s < 3; s++)
            if (prev_en_q[s]) v_d[s] = rdd3[prev_port_q[s]];
        case (state_q)
            IDLE: begin
                v_d = '0;
                if (iss_valid && !flush) begin
                    tag_d   = iss_tag;
                    vs_d    = {iss_vs3, iss_vs2, iss_vs1};
                    pend_d  = iss_src_en;
                    state_d = |iss_src_en ? REQ : OUT;
                end
            end
            REQ: begin
                pend_d    = pend_q & ~iss_m;
                prev_en_d = iss_m;
                state_d   = (pend_q & ~iss_m) == 3'b000 ? DRAIN : REQ;
            end
            DRAIN:   state_d = OUT;
            default: state_d = opnd_ready ? IDLE : OUT;
        endcase
        if (flush) begin
            state_d   = IDLE;
            pend_d    = '0;
            prev_en_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            vs_q        <= '0;
            pend_q      <= '0;
            prev_en_q   <= '0;
            prev_port_q <= '0;
            v_q         <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            vs_q        <= vs_d;
            pend_q      <= pend_d;
            prev_en_q   <= prev_en_d;
            prev_port_q <= prev_port_d;
            v_q         <= v_d;
        end
    end
endmodule

// File: tb/tb_vec_opnd_fetch.sv
// tb_vec_opnd_fetch: drives uops against a modelled VRF with 1-cycle read latency
// and scoreboards the operand bundles.
module tb_vec_opnd_fetch;
    localparam int XLEN = 512;
    localparam int NRD  = 2;
    localparam int TAGW = 8;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] v1, v2, v3;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, iss_valid = 1'b0, opnd_ready = 1'b0;
    logic iss_ready, opnd_valid;
    logic [TAGW-1:0] iss_tag = '0, opnd_tag;
    logic [2:0] iss_src_en = '0;
    logic [4:0] iss_vs1 = '0, iss_vs2 = '0, iss_vs3 = '0;
    logic [NRD-1:0] rd_en;
    logic [NRD*5-1:0] rd_addr;
    logic [NRD*XLEN-1:0] rd_data = '0;
    logic [XLEN-1:0] opnd_v1, opnd_v2, opnd_v3;
    exp_t exp_q[$];
    int n_vec = 0, n_bad = 0;

    vec_opnd_fetch #(.XLEN(XLEN), .NRD(NRD), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_tag(iss_tag), .iss_src_en(iss_src_en), .iss_vs1(iss_vs1), .iss_vs2(iss_vs2),
        .iss_vs3(iss_vs3), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_tag(opnd_tag),
        .opnd_v1(opnd_v1), .opnd_v2(opnd_v2), .opnd_v3(opnd_v3)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] vrf(input logic [4:0] idx);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN/32; i++)
            r[i*32 +: 32] = 32'h9E3779B9 * (32'(idx) + 1) + 32'(i);
        return r;
    endfunction

    // VRF model: enabled ports return data next cycle, idle ports return junk.
    always @(posedge clk) begin
        for (int k = 0; k < NRD; k++)
            rd_data[k*XLEN +: XLEN] <= rd_en[k] ? vrf(rd_addr[k*5 +: 5]) : {(XLEN/32){$urandom}};
    end

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [TAGW-1:0] tag, input logic [2:0] en,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        exp_t e;
        int n = 0;
        iss_valid = 1'b1; iss_tag = tag; iss_src_en = en;
        iss_vs1 = a; iss_vs2 = b; iss_vs3 = c;
        while (!iss_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("iss_timeout", XLEN'(iss_ready), XLEN'(1));
        e.tag = tag;
        e.v1 = en[0] ? vrf(a) : '0;
        e.v2 = en[1] ? vrf(b) : '0;
        e.v3 = en[2] ? vrf(c) : '0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 iss_valid = 1'b0;
    endtask

    task automatic take();
        exp_t e;
        int n = 0;
        while (!opnd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!opnd_valid || exp_q.size() == 0) begin
            check("out_timeout", XLEN'(opnd_valid && exp_q.size() != 0), XLEN'(1));
        end else begin
            e = exp_q.pop_front();
            check("tag", XLEN'(opnd_tag), XLEN'(e.tag));
            check("v1", opnd_v1, e.v1);
            check("v2", opnd_v2, e.v2);
            check("v3", opnd_v3, e.v3);
        end
        opnd_ready = 1'b1;
        @(posedge clk);
        #1 opnd_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_iss_ready", XLEN'(iss_ready), XLEN'(1));
        check("rst_valid", XLEN'(opnd_valid), XLEN'(0));
        check("rst_rd_en", XLEN'(rd_en), XLEN'(0));
        check("rst_rd_addr", XLEN'(rd_addr), XLEN'(0));
        check("rst_tag", XLEN'(opnd_tag), XLEN'(0));
        check("rst_v", opnd_v1 | opnd_v2 | opnd_v3, '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", XLEN'(iss_ready), XLEN'(1));
        check("idle_valid", XLEN'(opnd_valid), XLEN'(0));

        // three sources over two ports
        issue(8'h11, 3'b111, 5'd3, 5'd7, 5'd9);
        @(negedge clk);
        check("t3_c1_en", XLEN'(rd_en), XLEN'(2'b11));
        check("t3_c1_addr", XLEN'(rd_addr), XLEN'({5'd7, 5'd3}));
        @(negedge clk);
        check("t3_c2_en", XLEN'(rd_en), XLEN'(2'b01));
        check("t3_c2_addr", XLEN'(rd_addr), XLEN'({5'd0, 5'd9}));
        @(negedge clk);
        check("t3_c3_en", XLEN'(rd_en), XLEN'(0));
        check("t3_c3_valid", XLEN'(opnd_valid), XLEN'(0));
        @(negedge clk);
        check("t3_c4_valid", XLEN'(opnd_valid), XLEN'(1));
        take();

        // only vs3 enabled
        @(negedge clk);
        issue(8'h22, 3'b100, 5'd5, 5'd6, 5'd31);
        @(negedge clk);
        check("sp_c1_en", XLEN'(rd_en), XLEN'(2'b01));
        check("sp_c1_addr", XLEN'(rd_addr), XLEN'({5'd0, 5'd31}));
        @(negedge clk);
        check("sp_c2_valid", XLEN'(opnd_valid), XLEN'(0));
        @(negedge clk);
        check("sp_c3_valid", XLEN'(opnd_valid), XLEN'(1));
        take();

        // no sources
        @(negedge clk);
        issue(8'h5A, 3'b000, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        check("z_rd_en", XLEN'(rd_en), XLEN'(0));
        check("z_valid", XLEN'(opnd_valid), XLEN'(1));
        take();

        // backpressure with a competing uop held on the issue port
        @(negedge clk);
        issue(8'h33, 3'b011, 5'd1, 5'd2, 5'd0);
        iss_valid = 1'b1; iss_tag = 8'h44; iss_src_en = 3'b001; iss_vs1 = 5'd4;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", XLEN'(opnd_valid), XLEN'(1));
            check("bp_ready", XLEN'(iss_ready), XLEN'(0));
            check("bp_tag", XLEN'(opnd_tag), XLEN'(8'h33));
            check("bp_v2", opnd_v2, vrf(5'd2));
            @(negedge clk);
        end
        take();
        exp_q.push_back('{tag: 8'h44, v1: vrf(5'd4), v2: '0, v3: '0});
        @(negedge clk);
        check("bp_after_ready", XLEN'(iss_ready), XLEN'(1));
        @(posedge clk);
        #1 iss_valid = 1'b0;
        take();

        // flush in the cycle issuing vs3
        @(negedge clk);
        issue(8'h66, 3'b111, 5'd10, 5'd11, 5'd12);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        check("fl_en", XLEN'(rd_en), XLEN'(2'b01));
        flush = 1'b1;
        #1 check("fl_ready", XLEN'(iss_ready), XLEN'(0));
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fl_no_valid", XLEN'(opnd_valid), XLEN'(0));
        end
        issue(8'h77, 3'b111, 5'd12, 5'd13, 5'd14);
        take();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue(8'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom));
            take();
        end
        check("queue_empty", XLEN'(exp_q.size()), XLEN'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
